// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues pipelined in-order requests to a
// variable-latency instruction memory and buffers words in a prefetch FIFO. Define FETCH_BYPASS_EN to forward a response straight to the outputs when the FIFO is empty.
module instr_fetch_unit #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] fetch_pc, resp_pc;
    logic [CW-1:0]    inflight, discard, fifo_count;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [WIDTH-1:0] fifo_data [DEPTH];
    logic [WIDTH-1:0] fifo_tag  [DEPTH];
    logic             rv_ok, keep, grant, push, fifo_pop;
    logic [WIDTH-1:0] redir_tgt;
    logic [CW:0]      credit_used;

    // inflight counts every outstanding request, including ones already marked for discard
    assign rv_ok       = imem_rvalid && (inflight != '0);
    assign keep        = rv_ok && (discard == '0) && !redir_valid && !rst;
    assign credit_used = (CW+1)'(inflight) + (CW+1)'(fifo_count);
    assign imem_req    = !rst && !redir_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req && imem_gnt;
    assign redir_tgt   = redir_pc & ~WIDTH'(1);
    assign fifo_pop    = instr_ready && (fifo_count != '0);

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass      = keep && (fifo_count == '0);
    assign instr_valid = (fifo_count != '0) || bypass;
    assign instr       = bypass ? imem_rdata : fifo_data[rd_ptr];
    assign instr_pc    = bypass ? resp_pc    : fifo_tag[rd_ptr];
    assign push        = keep && !(bypass && instr_ready);
`else
    assign instr_valid = (fifo_count != '0);
    assign instr       = fifo_data[rd_ptr];
    assign instr_pc    = fifo_tag[rd_ptr];
    assign push        = keep;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            resp_pc    <= RESET_PC;
            inflight   <= '0;
            discard    <= '0;
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_tag[i]  <= RESET_PC;
            end
        end else begin
            inflight <= inflight + CW'(grant) - CW'(rv_ok);
            if (redir_valid) begin
                // the head may retire this cycle; everything else, and all that is still in flight, is stale
                discard    <= inflight - CW'(rv_ok);
                fetch_pc   <= redir_tgt;
                resp_pc    <= redir_tgt;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (rv_ok && (discard != '0))
                    discard <= discard - CW'(1);
                if (grant)
                    fetch_pc <= fetch_pc + WIDTH'(2);
                if (keep)
                    resp_pc <= resp_pc + WIDTH'(2);
                if (push) begin
                    fifo_data[wr_ptr] <= imem_rdata;
                    fifo_tag[wr_ptr]  <= resp_pc;
                    wr_ptr            <= wr_ptr + PW'(1);
                end
                if (fifo_pop)
                    rd_ptr <= rd_ptr + PW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(fifo_pop);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table and corner sequences, then random
// traffic checked against a request/generation-tag model of the fetch stream.
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, rst, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, redir_valid;
    logic [15:0] imem_addr, imem_rdata, instr, instr_pc, redir_pc;

    instr_fetch_unit #(.WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .redir_valid(redir_valid), .redir_pc(redir_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [15:0] addr; int gen; int due; } req_t;
    typedef struct { logic ready; logic exp_req; logic [15:0] exp_addr; logic exp_valid; logic [15:0] exp_pc; } vec_t;

    req_t        pend[$];
    logic [15:0] delivered[$];
    logic [15:0] granted[$];
    int          checks, errors, cyc, gen, buffered, lat_min, lat_max, gnt_pct, last_due;
    bit          spur;
    logic [15:0] exp_fetch, exp_deliver;
    logic        s_req, s_valid, s_rvalid, s_grant;
    logic [15:0] s_addr, s_instr, s_pc;

    function automatic logic [15:0] memw(input logic [15:0] a);
        return (a * 16'd7) ^ 16'hBEEF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model.
    task automatic step(input bit rdy, input bit rd, input logic [15:0] rpc, input bit r);
        bit kept_now, exp_req, exp_valid, pop, has_rv;
        int due;
        @(negedge clk);
        rst = r; instr_ready = rdy; redir_valid = rd; redir_pc = rpc;
        imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        has_rv      = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rvalid = has_rv || (spur && pend.size() == 0);
        imem_rdata  = has_rv ? memw(pend[0].addr) : 16'($urandom);
        #2;
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
        s_instr = instr; s_pc = instr_pc; s_rvalid = imem_rvalid;
        kept_now  = has_rv && (pend[0].gen == gen) && !rd && !r;
        exp_req   = !r && !rd && (pend.size() + buffered < DEPTH);
        exp_valid = (buffered > 0) || (BYP && kept_now);
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, exp_fetch);
        chk("instr_valid", instr_valid, exp_valid);
        if (exp_valid && instr_valid) begin
            chk("instr_pc", instr_pc, exp_deliver);
            chk("instr", instr, memw(exp_deliver));
        end
        s_grant = 1'b0;
        if (r) begin
            pend.delete(); gen++; buffered = 0; exp_fetch = 16'h0; exp_deliver = 16'h0;
        end else begin
            pop = exp_valid && rdy;
            if (has_rv) void'(pend.pop_front());
            s_grant = exp_req && imem_gnt;
            if (s_grant) begin
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                pend.push_back('{exp_fetch, gen, due});
                last_due = due;
                granted.push_back(exp_fetch);
                exp_fetch += 16'd2;
            end
            if (pop) begin
                delivered.push_back(s_pc);
                exp_deliver += 16'd2;
            end
            if (rd) begin
                gen++; buffered = 0;
                exp_fetch = rpc & 16'hFFFE; exp_deliver = rpc & 16'hFFFE;
            end else begin
                buffered += int'(kept_now) - int'(pop);
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        vec_t tbl[8];
        int   lat_v, g, rv_c, v_c, n;
        logic [15:0] exp_seq[3];
        checks = 0; errors = 0; cyc = 0; gen = 0; buffered = 0; last_due = 0; spur = 0;
        exp_fetch = 0; exp_deliver = 0;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        rst = 1; instr_ready = 0; redir_valid = 0; redir_pc = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;

        lat_v = BYP ? 1 : 2;
        for (int i = 0; i < 8; i++) begin
            tbl[i].ready     = 1'b1;
            tbl[i].exp_req   = 1'b1;
            tbl[i].exp_addr  = 16'(2 * i);
            tbl[i].exp_valid = (i >= lat_v);
            tbl[i].exp_pc    = (i >= lat_v) ? 16'(2 * (i - lat_v)) : 16'h0;
        end

        // reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_req", s_req, 1'b0);
        chk("rst_valid", s_valid, 1'b0);
        chk("rst_instr", s_instr, 16'h0);
        chk("rst_pc", s_pc, 16'h0);

        // linear fetch, 1-cycle memory
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].ready, 0, 0, 0);
            chk("tbl_req", s_req, tbl[i].exp_req);
            chk("tbl_addr", s_addr, tbl[i].exp_addr);
            chk("tbl_valid", s_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk("tbl_pc", s_pc, tbl[i].exp_pc);
        end

        // backpressure
        step(0, 0, 0, 1);
        g = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            g += int'(s_grant);
            if (s_valid) chk("bp_stable", s_instr, memw(16'h0));
        end
        chk("bp_grants", g, DEPTH);
        chk("bp_req_off", s_req, 1'b0);
        chk("bp_hold_pc", s_pc, 16'h0);
        delivered.delete();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        chk("bp_count", delivered.size() >= 5, 1'b1);
        for (int i = 0; i < 5 && i < delivered.size(); i++) chk("bp_order", delivered[i], 16'(2 * i));

        // redirect with two requests in flight, 3-cycle memory
        step(0, 0, 0, 1);
        lat_min = 3; lat_max = 3;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 16'h0041, 0);
        chk("redir_no_req", s_req, 1'b0);
        delivered.delete();
        step(1, 0, 0, 0);
        chk("redir_addr", s_addr, 16'h0040);
        chk("redir_valid_low", s_valid, 1'b0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        chk("redir_count", delivered.size() > 0, 1'b1);
        if (delivered.size() > 0) chk("redir_first_pc", delivered[0], 16'h0040);

        // wrap-around
        lat_min = 1; lat_max = 1;
        step(1, 1, 16'hFFFC, 0);
        granted.delete(); delivered.delete();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        exp_seq[0] = 16'hFFFC; exp_seq[1] = 16'hFFFE; exp_seq[2] = 16'h0000;
        chk("wrap_sizes", (granted.size() >= 3) && (delivered.size() >= 3), 1'b1);
        for (int i = 0; i < 3 && i < granted.size() && i < delivered.size(); i++) begin
            chk("wrap_addr", granted[i], exp_seq[i]);
            chk("wrap_pc", delivered[i], exp_seq[i]);
        end

        // redirect + pop + rvalid with three buffered words
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        delivered.delete();
        step(1, 1, 16'h0100, 0);
        chk("sim_rvalid", s_rvalid, 1'b1);
        chk("sim_head_pc", s_pc, 16'h0);
        chk("sim_popped", delivered.size(), 1);
        step(1, 0, 0, 0);
        chk("sim_valid_low", s_valid, 1'b0);
        chk("sim_new_addr", s_addr, 16'h0100);
        delivered.delete();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        if (delivered.size() > 0) chk("sim_first_pc", delivered[0], 16'h0100);
        else chk("sim_first_pc", 32'hFFFF_FFFF, 16'h0100);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("mid_rst_req", s_req, 1'b0);
        chk("mid_rst_valid", s_valid, 1'b0);
        step(1, 0, 0, 0);
        chk("mid_rst_addr", s_addr, 16'h0000);

        // latency to first instruction from response
        step(1, 0, 0, 1);
        rv_c = -1; v_c = -1;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0);
            if (s_rvalid && rv_c < 0) rv_c = i;
            if (s_valid && v_c < 0) v_c = i;
        end
        chk("bypass_latency", v_c - rv_c, BYP ? 0 : 1);

        // random traffic
        lat_min = 1; lat_max = 4; gnt_pct = 70;
        delivered.delete();
        for (int i = 0; i < 1200; i++) begin
            spur = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 16'($urandom),
                 $urandom_range(0, 299) == 0);
        end
        spur = 0;
        n = delivered.size();
        chk("rand_progress", n > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
